camera_emulator: RTL

//   Transmit side of the camera DVP bus. Generates pclk, v_sync, h_ref and 8-bit RGB565 pixel bytes

---
 rtl/camera_emulator_if.sv | 34 +++
 rtl/camera_emulator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/camera_emulator_if.sv
// DVP bus between the camera emulator and the camera receive path, plus the emulator's
// run controls. The master side is the emulator.
interface camera_emulator_if;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       pclk;
  logic       v_sync;
  logic       h_ref;
  logic [7:0] data_out;
  logic       frame_done;
  logic       busy;

  modport master (
    input  enable,
    input  pattern_sel,
    output pclk,
    output v_sync,
    output h_ref,
    output data_out,
    output frame_done,
    output busy
  );

  modport slave (
    output enable,
    output pattern_sel,
    input  pclk,
    input  v_sync,
    input  h_ref,
    input  data_out,
    input  frame_done,
    input  busy
  );
endinterface

// File: rtl/camera_emulator.sv
// OV7670-style DVP transmitter: pclk = clk_24/2, VGA frame timing and RGB565 test patterns,
// all outputs registered and updated only on pclk falling edges.
module camera_emulator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10
) (
  input logic               clk_24,
  input logic               reset_n,
  camera_emulator_if.master dvp_io
);

  localparam int unsigned LB       = 2 * (H_ACTIVE + H_BLANK);
  localparam int unsigned ActBytes = 2 * H_ACTIVE;
  localparam int unsigned BarW     = H_ACTIVE / 8;
  localparam int unsigned LineMax01 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned LineMax23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned LineMax   = (LineMax01 > LineMax23) ? LineMax01 : LineMax23;
  localparam int unsigned ByteW    = $clog2(LB);
  localparam int unsigned LineW    = $clog2(LineMax + 1);
  localparam int unsigned BarPxW   = (BarW > 1) ? $clog2(BarW) : 1;

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e             state_q, state_d;
  logic [ByteW-1:0]   byte_q, byte_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [BarPxW-1:0]  bar_px_q, bar_px_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               pclk_q;
  logic               v_sync_q;
  logic               h_ref_q;
  logic [7:0]         data_q;
  logic               frame_done_q;
  logic               busy_q;

  logic               tick;
  logic               frame_end;
  logic               byte_last;
  logic               line_last;
  int unsigned        state_lines;
  logic [5:0]         x_hi;
  logic               y_bit3;
  logic [15:0]        pix;
  logic               href_d;
  logic [7:0]         data_d;

  // pclk is high on the edge before it falls, so that edge is the tick.
  assign tick = pclk_q;

  always_comb begin
    state_lines = 1;
    case (state_q)
      StVsync:  state_lines = V_SYNC;
      StVback:  state_lines = V_BACK;
      StActive: state_lines = V_ACTIVE;
      StVfront: state_lines = V_FRONT;
      default:  state_lines = 1;
    endcase
  end

  assign byte_last = (byte_q == ByteW'(LB - 1));
  assign line_last = (line_q == LineW'(state_lines - 1));

  // Counters describe the byte being driven; the registered outputs follow the next position.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    line_d      = line_q;
    bar_px_d    = bar_px_q;
    bar_idx_d   = bar_idx_q;
    sel_d       = sel_q;
    frame_cnt_d = frame_cnt_q;
    frame_end   = 1'b0;
    if (tick) begin
      if (state_q == StIdle) begin
        if (dvp_io.enable) begin
          state_d   = StVsync;
          byte_d    = '0;
          line_d    = '0;
          bar_px_d  = '0;
          bar_idx_d = '0;
          sel_d     = dvp_io.pattern_sel;
        end
      end else if (!byte_last) begin
        byte_d = byte_q + 1'b1;
        if (byte_q[0]) begin
          if (bar_px_q == BarPxW'(BarW - 1)) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 1'b1;
          end else begin
            bar_px_d = bar_px_q + 1'b1;
          end
        end
      end else begin
        byte_d    = '0;
        bar_px_d  = '0;
        bar_idx_d = '0;
        if (!line_last) begin
          line_d = line_q + 1'b1;
        end else begin
          line_d = '0;
          case (state_q)
            StVsync:  state_d = StVback;
            StVback:  state_d = StActive;
            StActive: state_d = StVfront;
            StVfront: begin
              frame_end   = 1'b1;
              frame_cnt_d = frame_cnt_q + 1'b1;
              if (dvp_io.enable) begin
                state_d = StVsync;
                sel_d   = dvp_io.pattern_sel;
              end else begin
                state_d = StIdle;
              end
            end
            default:  state_d = StIdle;
          endcase
        end
      end
    end
  end

  // x_hi is x[7:2]; checkerboard and ramp only need these pixel bits.
  assign x_hi   = 6'(byte_d >> 3);
  assign y_bit3 = |(line_d & LineW'(8));

  always_comb begin
    pix = 16'h0000;
    case (sel_d)
      2'd0: begin
        case (bar_idx_d)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {x_hi[5:1], x_hi, x_hi[5:1]};
      2'd2:    pix = (x_hi[1] ^ y_bit3) ? 16'hFFFF : 16'h0000;
      default: pix = {frame_cnt_q, frame_cnt_q};
    endcase
  end

  assign href_d = (state_d == StActive) && (byte_d < ByteW'(ActBytes));
  assign data_d = !href_d ? 8'h00 : (byte_d[0] ? pix[7:0] : pix[15:8]);

  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      byte_q       <= '0;
      line_q       <= '0;
      bar_px_q     <= '0;
      bar_idx_q    <= '0;
      sel_q        <= '0;
      frame_cnt_q  <= '0;
      pclk_q       <= 1'b0;
      v_sync_q     <= 1'b0;
      h_ref_q      <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pclk_q       <= ~pclk_q;
      state_q      <= state_d;
      byte_q       <= byte_d;
      line_q       <= line_d;
      bar_px_q     <= bar_px_d;
      bar_idx_q    <= bar_idx_d;
      sel_q        <= sel_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_end;
      if (tick) begin
        v_sync_q <= (state_d == StVsync);
        h_ref_q  <= href_d;
        data_q   <= data_d;
        busy_q   <= (state_d != StIdle);
      end
    end
  end

  assign dvp_io.pclk       = pclk_q;
  assign dvp_io.v_sync     = v_sync_q;
  assign dvp_io.h_ref      = h_ref_q;
  assign dvp_io.data_out   = data_q;
  assign dvp_io.frame_done = frame_done_q;
  assign dvp_io.busy       = busy_q;

endmodule
